// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use bubble insertion and a saturating count of inserted bubbles.
module ex_operand_stage #(
    parameter int WIDTH = 16,
    parameter int RBITS = 3,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_ex_hold,
    input  logic             i_id_valid,
    input  logic [RBITS-1:0] i_id_rs,
    input  logic [RBITS-1:0] i_id_rt,
    input  logic [RBITS-1:0] i_id_rd,
    input  logic             i_id_uses_rs,
    input  logic             i_id_uses_rt,
    input  logic             i_id_wr_en,
    input  logic             i_id_is_load,
    input  logic [WIDTH-1:0] i_id_rs_data,
    input  logic [WIDTH-1:0] i_id_rt_data,
    input  logic [WIDTH-1:0] i_id_imm,
    input  logic             i_id_sel_imm,
    input  logic [2:0]       i_id_op,
    input  logic             i_id_cin,
    input  logic             i_id_inva,
    input  logic             i_id_invb,
    input  logic             i_id_clearb,
    input  logic             i_id_sign,
    input  logic [RBITS-1:0] i_mem_rd,
    input  logic             i_mem_wr_en,
    input  logic [WIDTH-1:0] i_mem_result,
    input  logic [RBITS-1:0] i_wb_rd,
    input  logic             i_wb_wr_en,
    input  logic [WIDTH-1:0] i_wb_result,
    output logic [WIDTH-1:0] o_ex_a,
    output logic [WIDTH-1:0] o_ex_b,
    output logic [2:0]       o_ex_op,
    output logic             o_ex_cin,
    output logic             o_ex_inva,
    output logic             o_ex_invb,
    output logic             o_ex_clearb,
    output logic             o_ex_sign,
    output logic             o_ex_valid,
    output logic             o_ex_wr_en,
    output logic             o_ex_is_load,
    output logic [RBITS-1:0] o_ex_rd,
    output logic             o_stall_id,
    output logic [CNTW-1:0]  o_stall_cnt
);
    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic             is_load;
        logic [RBITS-1:0] rd;
        logic [RBITS-1:0] rs;
        logic [RBITS-1:0] rt;
        logic             uses_rs;
        logic             uses_rt;
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [WIDTH-1:0] imm;
        logic             sel_imm;
        logic [2:0]       op;
        logic             cin;
        logic             inva;
        logic             invb;
        logic             clearb;
        logic             sign;
    } idex_t;

    idex_t            r_q;
    idex_t            w_d;
    logic [CNTW-1:0]  r_stall_cnt;
    logic             w_hazard;
    logic             w_bubble;
    logic [WIDTH-1:0] w_fwd_a;
    logic [WIDTH-1:0] w_fwd_b;

    assign w_hazard = r_q.valid & r_q.is_load & r_q.wr_en & i_id_valid &
                      ((i_id_uses_rs & (i_id_rs == r_q.rd)) | (i_id_uses_rt & (i_id_rt == r_q.rd)));
    // Flush beats hold; hold beats the hazard bubble.
    assign w_bubble   = i_flush | (~i_ex_hold & w_hazard);
    assign o_stall_id = ~i_flush & (w_hazard | i_ex_hold);

    always_comb begin
        w_d         = '0;
        w_d.valid   = i_id_valid;
        w_d.wr_en   = i_id_wr_en & i_id_valid;
        w_d.is_load = i_id_is_load & i_id_valid;
        w_d.rd      = i_id_rd;
        w_d.rs      = i_id_rs;
        w_d.rt      = i_id_rt;
        w_d.uses_rs = i_id_uses_rs;
        w_d.uses_rt = i_id_uses_rt;
        w_d.rs_data = i_id_rs_data;
        w_d.rt_data = i_id_rt_data;
        w_d.imm     = i_id_imm;
        w_d.sel_imm = i_id_sel_imm;
        w_d.op      = i_id_op;
        w_d.cin     = i_id_cin;
        w_d.inva    = i_id_inva;
        w_d.invb    = i_id_invb;
        w_d.clearb  = i_id_clearb;
        w_d.sign    = i_id_sign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (w_bubble)
            r_q <= '0;
        else if (!i_ex_hold)
            r_q <= w_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (!i_flush && !i_ex_hold && w_hazard && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    // EX/MEM is the younger result, so it wins over MEM/WB.
    always_comb begin
        w_fwd_a = (r_q.uses_rs && i_mem_wr_en && i_mem_rd == r_q.rs) ? i_mem_result :
                  (r_q.uses_rs && i_wb_wr_en && i_wb_rd == r_q.rs)   ? i_wb_result  : r_q.rs_data;
        w_fwd_b = (r_q.uses_rt && i_mem_wr_en && i_mem_rd == r_q.rt) ? i_mem_result :
                  (r_q.uses_rt && i_wb_wr_en && i_wb_rd == r_q.rt)   ? i_wb_result  : r_q.rt_data;
    end

    assign o_ex_a       = w_fwd_a;
    assign o_ex_b       = r_q.sel_imm ? r_q.imm : w_fwd_b;
    assign o_ex_op      = r_q.op;
    assign o_ex_cin     = r_q.cin;
    assign o_ex_inva    = r_q.inva;
    assign o_ex_invb    = r_q.invb;
    assign o_ex_clearb  = r_q.clearb;
    assign o_ex_sign    = r_q.sign;
    assign o_ex_valid   = r_q.valid;
    assign o_ex_wr_en   = r_q.wr_en;
    assign o_ex_is_load = r_q.is_load;
    assign o_ex_rd      = r_q.rd;
    assign o_stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed checks of capture, forwarding, load-use stall, flush, hold,
// async reset and stall-counter saturation (a narrow-counter instance shares the stimulus).
module tb_ex_operand_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, ex_hold, id_valid;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rs, id_uses_rt, id_wr_en, id_is_load;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_sel_imm;
    logic [2:0]  id_op;
    logic        id_cin, id_inva, id_invb, id_clearb, id_sign;
    logic [2:0]  mem_rd, wb_rd;
    logic        mem_wr_en, wb_wr_en;
    logic [15:0] mem_result, wb_result;
    logic [15:0] ex_a, ex_b;
    logic [2:0]  ex_op, ex_rd;
    logic        ex_cin, ex_inva, ex_invb, ex_clearb, ex_sign;
    logic        ex_valid, ex_wr_en, ex_is_load, stall_id;
    logic [15:0] stall_cnt;
    logic [15:0] s_a, s_b;
    logic [2:0]  s_op, s_rd;
    logic        s_cin, s_inva, s_invb, s_clearb, s_sign, s_valid, s_wr_en, s_is_load, s_stall_id;
    logic [3:0]  s_stall_cnt;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_ex_hold(ex_hold), .i_id_valid(id_valid),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd), .i_id_uses_rs(id_uses_rs),
        .i_id_uses_rt(id_uses_rt), .i_id_wr_en(id_wr_en), .i_id_is_load(id_is_load),
        .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data), .i_id_imm(id_imm),
        .i_id_sel_imm(id_sel_imm), .i_id_op(id_op), .i_id_cin(id_cin), .i_id_inva(id_inva),
        .i_id_invb(id_invb), .i_id_clearb(id_clearb), .i_id_sign(id_sign),
        .i_mem_rd(mem_rd), .i_mem_wr_en(mem_wr_en), .i_mem_result(mem_result),
        .i_wb_rd(wb_rd), .i_wb_wr_en(wb_wr_en), .i_wb_result(wb_result),
        .o_ex_a(ex_a), .o_ex_b(ex_b), .o_ex_op(ex_op), .o_ex_cin(ex_cin), .o_ex_inva(ex_inva),
        .o_ex_invb(ex_invb), .o_ex_clearb(ex_clearb), .o_ex_sign(ex_sign), .o_ex_valid(ex_valid),
        .o_ex_wr_en(ex_wr_en), .o_ex_is_load(ex_is_load), .o_ex_rd(ex_rd),
        .o_stall_id(stall_id), .o_stall_cnt(stall_cnt)
    );

    ex_operand_stage #(.CNTW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_ex_hold(ex_hold), .i_id_valid(id_valid),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd), .i_id_uses_rs(id_uses_rs),
        .i_id_uses_rt(id_uses_rt), .i_id_wr_en(id_wr_en), .i_id_is_load(id_is_load),
        .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data), .i_id_imm(id_imm),
        .i_id_sel_imm(id_sel_imm), .i_id_op(id_op), .i_id_cin(id_cin), .i_id_inva(id_inva),
        .i_id_invb(id_invb), .i_id_clearb(id_clearb), .i_id_sign(id_sign),
        .i_mem_rd(mem_rd), .i_mem_wr_en(mem_wr_en), .i_mem_result(mem_result),
        .i_wb_rd(wb_rd), .i_wb_wr_en(wb_wr_en), .i_wb_result(wb_result),
        .o_ex_a(s_a), .o_ex_b(s_b), .o_ex_op(s_op), .o_ex_cin(s_cin), .o_ex_inva(s_inva),
        .o_ex_invb(s_invb), .o_ex_clearb(s_clearb), .o_ex_sign(s_sign), .o_ex_valid(s_valid),
        .o_ex_wr_en(s_wr_en), .o_ex_is_load(s_is_load), .o_ex_rd(s_rd),
        .o_stall_id(s_stall_id), .o_stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; ex_hold = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_wr_en = 0; id_is_load = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_sel_imm = 0; id_op = 0;
        id_cin = 0; id_inva = 0; id_invb = 0; id_clearb = 0; id_sign = 0;
        mem_rd = 0; mem_wr_en = 0; mem_result = 0; wb_rd = 0; wb_wr_en = 0; wb_result = 0;
    endtask

    task automatic alu(input logic [2:0] rd, rs, rt, input logic [15:0] a, b);
        id_valid = 1; id_rd = rd; id_rs = rs; id_rt = rt; id_uses_rs = 1; id_uses_rt = 1;
        id_wr_en = 1; id_is_load = 0; id_rs_data = a; id_rt_data = b; id_sel_imm = 0;
    endtask

    task automatic load(input logic [2:0] rd, rs);
        id_valid = 1; id_rd = rd; id_rs = rs; id_rt = 0; id_uses_rs = 1; id_uses_rt = 0;
        id_wr_en = 1; id_is_load = 1; id_rs_data = 16'h0010; id_sel_imm = 1; id_imm = 16'h0002;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #12;
        chk("rst_valid", ex_valid, 0);
        chk("rst_wr_en", ex_wr_en, 0);
        chk("rst_a", ex_a, 0);
        chk("rst_b", ex_b, 0);
        chk("rst_op", ex_op, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_stall", stall_id, 0);
        rst_n = 1;
        // capture ADD r3,r1,r2
        alu(3, 1, 2, 16'h0005, 16'h0007);
        id_op = 3'b010; id_cin = 1; id_sign = 1;
        tick();
        chk("add_a", ex_a, 16'h0005);
        chk("add_b", ex_b, 16'h0007);
        chk("add_valid", ex_valid, 1);
        chk("add_rd", ex_rd, 3);
        chk("add_op", ex_op, 3'b010);
        chk("add_cin", ex_cin, 1);
        chk("add_sign", ex_sign, 1);
        chk("add_stall", stall_id, 0);
        // forwarding priority and sources
        mem_wr_en = 1; mem_rd = 1; mem_result = 16'h1234;
        wb_wr_en = 1; wb_rd = 1; wb_result = 16'hBEEF;
        #1 chk("fwd_mem_pri", ex_a, 16'h1234);
        chk("fwd_b_plain", ex_b, 16'h0007);
        mem_wr_en = 0;
        #1 chk("fwd_wb", ex_a, 16'hBEEF);
        wb_rd = 2;
        #1 chk("fwd_wb_b", ex_b, 16'hBEEF);
        chk("fwd_a_plain", ex_a, 16'h0005);
        mem_wr_en = 1; mem_rd = 2; mem_result = 16'h5A5A;
        #1 chk("fwd_mem_b", ex_b, 16'h5A5A);
        // immediate B with unused rt: forwards must not touch B
        idle();
        alu(6, 5, 2, 16'h0101, 16'h0202);
        id_uses_rt = 0; id_sel_imm = 1; id_imm = 16'h00FF; id_inva = 1; id_invb = 1; id_clearb = 1;
        tick();
        wb_wr_en = 1; wb_rd = 2; wb_result = 16'hCAFE;
        #1 chk("imm_b", ex_b, 16'h00FF);
        chk("imm_inva", ex_inva, 1);
        chk("imm_invb", ex_invb, 1);
        chk("imm_clearb", ex_clearb, 1);
        // invalid instruction: wr_en gated
        idle();
        id_wr_en = 1; id_is_load = 1;
        tick();
        chk("inv_valid", ex_valid, 0);
        chk("inv_wr_en", ex_wr_en, 0);
        chk("inv_is_load", ex_is_load, 0);
        // load-use stall
        load(4, 1);
        tick();
        chk("ld_is_load", ex_is_load, 1);
        alu(5, 6, 4, 16'h0011, 16'hDEAD);
        id_uses_rt = 0;
        #1 chk("ld_unused_rt", stall_id, 0);
        id_uses_rt = 1; id_valid = 0;
        #1 chk("ld_invalid_id", stall_id, 0);
        id_valid = 1;
        #1 chk("ld_hazard", stall_id, 1);
        tick();
        chk("bub_valid", ex_valid, 0);
        chk("bub_wr_en", ex_wr_en, 0);
        chk("bub_cnt", stall_cnt, 1);
        chk("bub_stall", stall_id, 0);
        tick();
        wb_wr_en = 1; wb_rd = 4; wb_result = 16'h4444;
        #1 chk("ld_use_b", ex_b, 16'h4444);
        chk("ld_use_a", ex_a, 16'h0011);
        chk("ld_use_valid", ex_valid, 1);
        chk("ld_use_rd", ex_rd, 5);
        chk("ld_use_cnt", stall_cnt, 1);
        // hazard with flush
        idle();
        load(4, 1);
        tick();
        alu(5, 4, 1, 16'h0001, 16'h0002);
        flush = 1;
        #1 chk("fl_stall", stall_id, 0);
        tick();
        chk("fl_valid", ex_valid, 0);
        chk("fl_cnt", stall_cnt, 1);
        // ex_hold for three cycles
        idle();
        alu(3, 1, 2, 16'h0005, 16'h0007);
        id_op = 3'b001;
        tick();
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            id_rs_data = 16'h9990 + 16'(i); id_rd = 7; id_op = 3'b101;
            #1 chk("hold_stall", stall_id, 1);
            tick();
            chk("hold_a", ex_a, 16'h0005);
            chk("hold_rd", ex_rd, 3);
            chk("hold_op", ex_op, 3'b001);
        end
        ex_hold = 0;
        tick();
        chk("resume_a", ex_a, 16'h9992);
        chk("resume_rd", ex_rd, 7);
        ex_hold = 1; flush = 1;
        #1 chk("holdfl_stall", stall_id, 0);
        tick();
        chk("holdfl_valid", ex_valid, 0);
        // async reset mid-hold with a pending hazard
        idle();
        load(4, 1);
        tick();
        alu(5, 4, 1, 16'h0001, 16'h0002);
        ex_hold = 1;
        #2 rst_n = 0;
        #1 chk("arst_valid", ex_valid, 0);
        chk("arst_cnt", stall_cnt, 0);
        ex_hold = 0;
        #1 chk("arst_stall", stall_id, 0);
        rst_n = 1;
        // saturation: LD r4,(r4) repeatedly stalls every other cycle
        idle();
        load(4, 4);
        for (int i = 0; i < 40; i++) tick();
        chk("cnt_20", stall_cnt, 20);
        chk("sat_15", s_stall_cnt, 4'hF);
        tick();
        #1 chk("sat_stall", s_stall_id, 1);
        tick();
        chk("cnt_21", stall_cnt, 21);
        chk("sat_hold", s_stall_cnt, 4'hF);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register and operand-select stage sitting directly upstream of the execute-stage ALU in the 5-stage 16-bit pipeline.
- Captures decoded fields and register-file reads each cycle.
- Forwards results from EX/MEM and MEM/WB into the A/B operands.
- Detects load-use hazards, inserts one bubble and stalls IF/ID.
- Drives the ALU control lines (op, cin, inversions, clearB, sign) from registered state.

Parameters:
WIDTH, 16, datapath width
RBITS, 3, register index width (8 GPRs, r0 is ordinary)
CNTW, 16, stall-counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  branch/jump mispredict; kill instruction entering EX
ex_hold  in  1  back-end freeze (memory busy); MEM/WB regs also frozen
id_valid  in  1  ID holds a real instruction
id_rs, id_rt, id_rd  in  RBITS  source/destination indices
id_uses_rs, id_uses_rt  in  1  source actually read
id_wr_en, id_is_load  in  1  writes rd / is a load
id_rs_data, id_rt_data  in  WIDTH  register-file read data
id_imm  in  WIDTH  extended immediate
id_sel_imm  in  1  B operand = immediate
id_op  in  3  ALU op; id_cin, id_inva, id_invb, id_clearb, id_sign  in  1 each
mem_rd  in  RBITS; mem_wr_en  in  1; mem_result  in  WIDTH  EX/MEM forward source
wb_rd  in  RBITS; wb_wr_en  in  1; wb_result  in  WIDTH  MEM/WB forward source
ex_a, ex_b  out  WIDTH  ALU operands
ex_op  out  3; ex_cin, ex_inva, ex_invb, ex_clearb, ex_sign  out  1  ALU controls
ex_valid, ex_wr_en, ex_is_load  out  1; ex_rd  out  RBITS  to EX/MEM
stall_id  out  1  freeze PC and IF/ID
stall_cnt  out  CNTW  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, rst_n=0):
  - All registered fields 0: ex_valid=0, ex_wr_en=0, ex_is_load=0, ex_op=000, controls 0, stored data 0.
  - stall_cnt=0.
  - ex_a/ex_b then read 0 unless a forward matches (wr_en gating makes matches impossible while valid=0 downstream).
- hazard (comb) = ex_valid & ex_is_load & ex_wr_en & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- stall_id (comb) = !flush & (hazard | ex_hold).
- Register update priority each edge:
  1. flush: load bubble (valid/wr_en/is_load=0, other fields don't-care but zeroed). Flush overrides ex_hold and hazard.
  2. ex_hold: all registers keep value.
  3. hazard: load bubble; stall_cnt += 1 unless at all-ones (saturate).
  4. else: capture all id_* fields. ex_valid=id_valid; ex_wr_en=id_wr_en&id_valid; ex_is_load=id_is_load&id_valid.
- Forwarding (comb, on registered rs/rt), for each source operand:
  - if uses & mem_wr_en & mem_rd==reg → mem_result;
  - elif uses & wb_wr_en & wb_rd==reg → wb_result;
  - else stored register-file data.
  - EX/MEM has priority over MEM/WB when both match.
  - Load data is never forwarded from MEM; the one-cycle bubble guarantees it arrives via WB.
- ex_a = forwarded rs. ex_b = stored imm if sel_imm, else forwarded rt.
- ALU controls pass through from registers unchanged.
- Latency: one cycle ID→EX; forward path zero-cycle combinational.
- A bubble leaves the ALU computing garbage; downstream must gate on ex_valid/ex_wr_en only.
- Same-cycle flush and hazard: bubble, stall_id=0, stall_cnt unchanged.
- Reset mid-stall: stall_id drops because ex_valid=0.

Test Plan:
1. Reset, then ADD r3,r1,r2 with id_rs_data=0x0005, id_rt_data=0x0007, no matches → next cycle ex_a=0x0005, ex_b=0x0007, ex_valid=1, ex_rd=3, stall_id=0.
2. Back-to-back dependence: EX/MEM writes r1=0x1234 and MEM/WB writes r1=0xBEEF while EX instr uses rs=r1 → ex_a=0x1234. With MEM/WB match only → ex_a=0xBEEF.
3. LD r4 in EX followed by ID instr using rt=r4 → stall_id=1 for exactly one cycle, next ex_valid=0, stall_cnt=1. The instruction then enters EX and takes rt from wb_result.
4. Load-use hazard with flush=1 in the same cycle → stall_id=0, ex_valid=0 next cycle, stall_cnt unchanged.
5. ex_hold=1 for 3 cycles with changing id_* inputs → ex_* registers unchanged and stall_id=1 throughout; capture resumes on the first cycle ex_hold=0.
6. Drive rst_n low mid-hold, asynchronously between edges → ex_valid=0, stall_cnt=0 immediately. Separately, force 0xFFFF load-use stalls → stall_cnt stays 0xFFFF.
